// File: rtl/cpu_pkg.sv
// Shared CPU definitions: widths, opcodes, ALU function selects, sequencer
// states and the decoded-instruction payload. The datapath ALU decodes the
// same FS_* constants.
package cpu_pkg;

    localparam int unsigned PC_W   = 6;
    localparam int unsigned IR_W   = 16;
    localparam int unsigned REG_AW = 4;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned FS_W   = 4;

    // Opcodes (IR[15:12]); 4'hE is reserved and executes as NOP
    localparam logic [OP_W-1:0] OP_NOP = 4'h0;
    localparam logic [OP_W-1:0] OP_ADD = 4'h1;
    localparam logic [OP_W-1:0] OP_SUB = 4'h2;
    localparam logic [OP_W-1:0] OP_AND = 4'h3;
    localparam logic [OP_W-1:0] OP_OR  = 4'h4;
    localparam logic [OP_W-1:0] OP_XOR = 4'h5;
    localparam logic [OP_W-1:0] OP_NOT = 4'h6;
    localparam logic [OP_W-1:0] OP_MOV = 4'h7;
    localparam logic [OP_W-1:0] OP_ADI = 4'h8;
    localparam logic [OP_W-1:0] OP_LD  = 4'h9;
    localparam logic [OP_W-1:0] OP_ST  = 4'hA;
    localparam logic [OP_W-1:0] OP_BZ  = 4'hB;
    localparam logic [OP_W-1:0] OP_BNZ = 4'hC;
    localparam logic [OP_W-1:0] OP_JMP = 4'hD;
    localparam logic [OP_W-1:0] OP_RSV = 4'hE;
    localparam logic [OP_W-1:0] OP_HLT = 4'hF;

    // ALU function selects; MOVA is zero so idle cycles present FS=0
    localparam logic [FS_W-1:0] FS_MOVA = 4'h0;
    localparam logic [FS_W-1:0] FS_ADD  = 4'h2;
    localparam logic [FS_W-1:0] FS_SUB  = 4'h5;
    localparam logic [FS_W-1:0] FS_AND  = 4'h8;
    localparam logic [FS_W-1:0] FS_OR   = 4'h9;
    localparam logic [FS_W-1:0] FS_XOR  = 4'hA;
    localparam logic [FS_W-1:0] FS_NOTA = 4'hB;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_MEM   = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    // Decoded instruction: ALU select plus one-hot-ish class flags
    typedef struct packed {
        logic [FS_W-1:0] fs;
        logic            mb;
        logic            alu;
        logic            ld;
        logic            st;
        logic            br;
        logic            br_inv;  // BNZ: branch when Z=0
        logic            jmp;
        logic            hlt;
    } decode_t;

endpackage

// File: rtl/control_sequencer_if.sv
// Sequencer <-> datapath/memory bundle.
//   master (sequencer): in  instr_in, mem_ready, Z
//                       out DR, SA, SB, FS, PC, MB, MM, MD, RW, MW, halted
//   slave  (datapath):  mirror image of master
interface control_sequencer_if #(
    parameter int unsigned PC_W   = 6,
    parameter int unsigned IR_W   = 16,
    parameter int unsigned REG_AW = 4,
    parameter int unsigned FS_W   = 4
);
    logic [IR_W-1:0]   instr_in;
    logic              mem_ready;
    logic              Z;
    logic [REG_AW-1:0] DR;
    logic [REG_AW-1:0] SA;
    logic [REG_AW-1:0] SB;
    logic [FS_W-1:0]   FS;
    logic [PC_W-1:0]   PC;
    logic              MB;
    logic              MM;
    logic              MD;
    logic              RW;
    logic              MW;
    logic              halted;

    modport master (
        input  instr_in, mem_ready, Z,
        output DR, SA, SB, FS, PC, MB, MM, MD, RW, MW, halted
    );

    modport slave (
        output instr_in, mem_ready, Z,
        input  DR, SA, SB, FS, PC, MB, MM, MD, RW, MW, halted
    );
endinterface

// File: rtl/instr_decode.sv
// Combinational opcode decoder: opcode -> ALU select, MB, instruction class.
//   opcode : IR[15:12]
//   dec    : decoded payload (cpu_pkg::decode_t)
module instr_decode
    import cpu_pkg::*;
(
    input  logic [OP_W-1:0] opcode,
    output decode_t         dec
);

    always_comb begin
        dec = '0;
        case (opcode)
            OP_ADD: begin dec.alu = 1'b1; dec.fs = FS_ADD;  end
            OP_SUB: begin dec.alu = 1'b1; dec.fs = FS_SUB;  end
            OP_AND: begin dec.alu = 1'b1; dec.fs = FS_AND;  end
            OP_OR:  begin dec.alu = 1'b1; dec.fs = FS_OR;   end
            OP_XOR: begin dec.alu = 1'b1; dec.fs = FS_XOR;  end
            OP_NOT: begin dec.alu = 1'b1; dec.fs = FS_NOTA; end
            OP_MOV: begin dec.alu = 1'b1; dec.fs = FS_MOVA; end
            OP_ADI: begin dec.alu = 1'b1; dec.fs = FS_ADD; dec.mb = 1'b1; end
            OP_LD:  dec.ld  = 1'b1;
            OP_ST:  dec.st  = 1'b1;
            // Branches pass the test register through the ALU to produce Z
            OP_BZ:  begin dec.br = 1'b1; dec.fs = FS_MOVA; end
            OP_BNZ: begin dec.br = 1'b1; dec.br_inv = 1'b1; dec.fs = FS_MOVA; end
            OP_JMP: dec.jmp = 1'b1;
            OP_HLT: dec.hlt = 1'b1;
            default: ;  // NOP and reserved
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer: FETCH -> EXEC [-> MEM] -> FETCH, HALT absorbing.
// Owns state, IR and PC; all other controls are decoded from state and IR.
//   clk_main : system clock
//   reset    : synchronous active-high reset
//   bus      : control_sequencer_if.master (memory data/handshake, Z flag in;
//              register/ALU/memory controls and PC out)
module control_sequencer #(
    parameter int unsigned PC_W   = 6,
    parameter int unsigned IR_W   = 16,
    parameter int unsigned REG_AW = 4
) (
    input  logic                 clk_main,
    input  logic                 reset,
    control_sequencer_if.master  bus
);
    import cpu_pkg::*;

    state_t            state, state_nxt;
    logic [IR_W-1:0]   ir, ir_nxt;
    logic [PC_W-1:0]   pc, pc_nxt, pc_inc, pc_tgt;
    decode_t           dec;
    logic              taken;

    logic [REG_AW-1:0] dr, sa, sb;
    logic [FS_W-1:0]   fs;
    logic              mb, mm, md, rw, mw, halted;

    instr_decode u_decode (
        .opcode (ir[IR_W-1 -: OP_W]),
        .dec    (dec)
    );

    assign pc_inc = pc + PC_W'(1);  // natural wrap at 2^PC_W
    assign pc_tgt = ir[PC_W-1:0];
    assign taken  = dec.br_inv ? ~bus.Z : bus.Z;

    // State, IR and PC registers
    always_ff @(posedge clk_main) begin
        if (reset) begin
            state <= ST_FETCH;
            ir    <= '0;
            pc    <= '0;
        end else begin
            state <= state_nxt;
            ir    <= ir_nxt;
            pc    <= pc_nxt;
        end
    end

    // Next-state, IR/PC update and control outputs
    always_comb begin
        state_nxt = state;
        ir_nxt    = ir;
        pc_nxt    = pc;
        dr        = '0;
        sa        = '0;
        sb        = '0;
        fs        = FS_MOVA;
        mb        = 1'b0;
        mm        = 1'b1;
        md        = 1'b0;
        rw        = 1'b0;
        mw        = 1'b0;
        halted    = 1'b0;

        case (state)
            ST_FETCH: begin
                if (bus.mem_ready) begin
                    ir_nxt    = bus.instr_in;
                    state_nxt = ST_EXEC;
                end
            end

            ST_EXEC: begin
                state_nxt = ST_FETCH;
                pc_nxt    = pc_inc;
                if (dec.alu) begin
                    dr = ir[8 +: REG_AW];
                    sa = ir[4 +: REG_AW];
                    sb = ir[0 +: REG_AW];
                    fs = dec.fs;
                    mb = dec.mb;
                    rw = 1'b1;
                end else if (dec.ld || dec.st) begin
                    state_nxt = ST_MEM;
                    pc_nxt    = pc;
                end else if (dec.br) begin
                    sa = ir[8 +: REG_AW];
                    fs = dec.fs;
                    if (taken) begin
                        pc_nxt = pc_tgt;
                    end
                end else if (dec.jmp) begin
                    pc_nxt = pc_tgt;
                end else if (dec.hlt) begin
                    state_nxt = ST_HALT;
                    pc_nxt    = pc;
                end
            end

            ST_MEM: begin
                mm = 1'b0;
                sa = ir[4 +: REG_AW];
                sb = ir[0 +: REG_AW];
                if (dec.st) begin
                    mw = 1'b1;
                end else begin
                    md = 1'b1;
                    dr = ir[8 +: REG_AW];
                    rw = bus.mem_ready;  // write back only when the data is valid
                end
                if (bus.mem_ready) begin
                    pc_nxt    = pc_inc;
                    state_nxt = ST_FETCH;
                end
            end

            ST_HALT: halted = 1'b1;

            default: state_nxt = ST_FETCH;
        endcase

        // An aborted cycle must not commit anything
        if (reset) begin
            rw = 1'b0;
            mw = 1'b0;
        end
    end

    assign bus.DR     = dr;
    assign bus.SA     = sa;
    assign bus.SB     = sb;
    assign bus.FS     = fs;
    assign bus.PC     = pc;
    assign bus.MB     = mb;
    assign bus.MM     = mm;
    assign bus.MD     = md;
    assign bus.RW     = rw;
    assign bus.MW     = mw;
    assign bus.halted = halted;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed scenarios plus randomized instruction
// streams, checked cycle by cycle against an instruction-level model.
module tb_control_sequencer;
    import cpu_pkg::*;

    localparam int PH_FETCH = 0;
    localparam int PH_EXEC  = 1;
    localparam int PH_MEM   = 2;
    localparam int PH_HALT  = 3;

    logic clk_main = 1'b0;
    logic reset;
    always #5 clk_main = ~clk_main;

    control_sequencer_if #(.PC_W(6), .IR_W(16), .REG_AW(4), .FS_W(4)) bus ();

    control_sequencer #(.PC_W(6), .IR_W(16), .REG_AW(4)) dut (
        .clk_main (clk_main),
        .reset    (reset),
        .bus      (bus)
    );

    int passed = 0;
    int total  = 0;
    int pc_m   = 0;   // model program counter

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [3:0] fs_of(input logic [3:0] op);
        case (op)
            4'h1: return FS_ADD;
            4'h2: return FS_SUB;
            4'h3: return FS_AND;
            4'h4: return FS_OR;
            4'h5: return FS_XOR;
            4'h6: return FS_NOTA;
            4'h7: return FS_MOVA;
            4'h8: return FS_ADD;
            default: return FS_MOVA;
        endcase
    endfunction

    // Expected {halted,MW,RW,MD,MM,MB,FS,SB,SA,DR} for a given phase
    function automatic logic [21:0] expect_out(input int phase, input logic [15:0] ir,
                                               input logic rdy, input logic rst);
        logic [3:0] op, f1, f2, f3, dr, sa, sb, fs;
        logic mb, mm, md, rw, mw, h;
        op = ir[15:12]; f1 = ir[11:8]; f2 = ir[7:4]; f3 = ir[3:0];
        dr = 4'h0; sa = 4'h0; sb = 4'h0; fs = FS_MOVA;
        mb = 1'b0; mm = 1'b1; md = 1'b0; rw = 1'b0; mw = 1'b0; h = 1'b0;
        if (phase == PH_EXEC) begin
            if (op >= 4'h1 && op <= 4'h8) begin
                dr = f1; sa = f2; sb = f3; fs = fs_of(op);
                mb = (op == 4'h8); rw = 1'b1;
            end else if (op == 4'hB || op == 4'hC) begin
                sa = f1; fs = FS_MOVA;
            end
        end else if (phase == PH_MEM) begin
            mm = 1'b0; sa = f2; sb = f3;
            if (op == 4'hA) mw = 1'b1;
            if (op == 4'h9) begin md = 1'b1; dr = f1; rw = rdy; end
        end else if (phase == PH_HALT) begin
            h = 1'b1;
        end
        if (rst) begin rw = 1'b0; mw = 1'b0; end
        return {h, mw, rw, md, mm, mb, fs, sb, sa, dr};
    endfunction

    function automatic logic [21:0] observed();
        return {bus.halted, bus.MW, bus.RW, bus.MD, bus.MM, bus.MB,
                bus.FS, bus.SB, bus.SA, bus.DR};
    endfunction

    // Inputs are already driven; sample mid-cycle and compare
    task automatic check_cycle(input string tag, input int phase, input logic [15:0] ir);
        #1;
        chk(tag, 32'(observed()), 32'(expect_out(phase, ir, bus.mem_ready, reset)));
        chk({tag, "_pc"}, 32'(bus.PC), 32'(pc_m));
    endtask

    // Execute one instruction end to end; abort=1 asserts reset in the first MEM cycle
    task automatic run_instr(input logic [15:0] ir, input int fstall, input int mstall,
                             input logic z, input bit abort);
        logic [3:0] op;
        int tgt;
        op  = ir[15:12];
        tgt = int'(ir[5:0]);
        for (int i = 0; i < fstall; i++) begin
            bus.instr_in = 16'($urandom); bus.mem_ready = 1'b0; bus.Z = 1'($urandom);
            check_cycle("fetch_wait", PH_FETCH, ir);
            @(negedge clk_main);
        end
        bus.instr_in = ir; bus.mem_ready = 1'b1;
        check_cycle("fetch", PH_FETCH, ir);
        @(negedge clk_main);

        bus.instr_in = 16'($urandom); bus.mem_ready = 1'($urandom); bus.Z = z;
        check_cycle("exec", PH_EXEC, ir);
        @(negedge clk_main);

        case (op)
            4'hB: pc_m = z  ? tgt : (pc_m + 1) % 64;
            4'hC: pc_m = !z ? tgt : (pc_m + 1) % 64;
            4'hD: pc_m = tgt;
            4'h9, 4'hA, 4'hF: ;
            default: pc_m = (pc_m + 1) % 64;
        endcase

        if (op == 4'h9 || op == 4'hA) begin
            if (abort) begin
                reset = 1'b1; bus.mem_ready = 1'($urandom); bus.Z = 1'($urandom);
                check_cycle("mem_reset", PH_MEM, ir);
                @(negedge clk_main);
                reset = 1'b0;
                pc_m  = 0;
                return;
            end
            for (int i = 0; i < mstall; i++) begin
                bus.mem_ready = 1'b0; bus.Z = 1'($urandom);
                check_cycle("mem_wait", PH_MEM, ir);
                @(negedge clk_main);
            end
            bus.mem_ready = 1'b1;
            check_cycle("mem_done", PH_MEM, ir);
            @(negedge clk_main);
            pc_m = (pc_m + 1) % 64;
        end
    endtask

    initial begin
        reset = 1'b1; bus.instr_in = '0; bus.mem_ready = 1'b0; bus.Z = 1'b0;
        @(negedge clk_main);
        @(negedge clk_main);
        pc_m = 0;
        check_cycle("reset_state", PH_FETCH, 16'h0000);
        reset = 1'b0;

        // ADD R1,R2,R3
        run_instr(16'h1123, 0, 0, 1'b0, 1'b0);
        // LD R4,(R5) with memory stalls
        run_instr(16'h9450, 1, 3, 1'b0, 1'b0);
        // Conditional branches, both polarities
        run_instr(16'hB22A, 0, 0, 1'b1, 1'b0);
        run_instr(16'hB22A, 2, 0, 1'b0, 1'b0);
        run_instr(16'hC22A, 0, 0, 1'b0, 1'b0);
        run_instr(16'hC22A, 0, 0, 1'b1, 1'b0);
        // ADI uses constant B operand
        run_instr(16'h8ABC, 0, 0, 1'b0, 1'b0);
        // Jump to the last address, then NOP wraps PC to 0
        run_instr(16'hD03F, 0, 0, 1'b0, 1'b0);
        run_instr(16'h0000, 0, 0, 1'b0, 1'b0);
        #1 chk("pc_wrap", 32'(bus.PC), 32'd0);
        // ST, stall, and reserved opcode
        run_instr(16'hA123, 0, 2, 1'b0, 1'b0);
        run_instr(16'hE777, 1, 0, 1'b1, 1'b0);

        // Random instruction stream (no HLT)
        for (int n = 0; n < 150; n++) begin
            logic [15:0] ir;
            ir = {4'($urandom_range(0, 14)), 12'($urandom)};
            run_instr(ir, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      1'($urandom), 1'b0);
        end

        // ST aborted by reset mid-MEM
        run_instr(16'hA5C3, 0, 0, 1'b0, 1'b1);
        run_instr(16'h2345, 0, 0, 1'b0, 1'b0);

        // HLT is absorbing
        run_instr(16'hF000, 0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            bus.instr_in = 16'($urandom); bus.mem_ready = 1'($urandom); bus.Z = 1'($urandom);
            check_cycle("halt", PH_HALT, 16'hF000);
            @(negedge clk_main);
        end
        reset = 1'b1; bus.mem_ready = 1'b0;
        @(negedge clk_main);
        reset = 1'b0;
        pc_m  = 0;
        check_cycle("after_halt_reset", PH_FETCH, 16'h0000);
        @(negedge clk_main);
        run_instr(16'h5321, 1, 0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
